alu_seq_ctrl: RTL
=================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-cycle control sequencer that drives the 16-bit ALU. It is the ALU's issuing end.
//  - Issues ALUop and operands; consumes result and branch.
//  - Fetches 16-bit instructions over a req/ack instruction-memory port.
//  - Reads and writes the 16x16 register file; owns and updates the PC.
//  - Sits between imem, the register file and the ALU. Drives one instruction per FETCH-DECODE-EXEC-WB pass.
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded at reset
//  LINK_REG   4'd15     register written with return address by BL
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  run          in   1   start request, sampled only in IDLE
//  imem_req     out  1   fetch request
//  imem_addr    out  16  fetch address (= pc)
//  imem_ack     in   1   fetch complete; imem_data valid same cycle
//  imem_data    in   16  instruction word
//  rf_ra        out  4   regfile read addr A (combinational read)
//  rf_rb        out  4   regfile read addr B
//  rf_rdata_a   in   16  read data A
//  rf_rdata_b   in   16  read data B
//  rf_we        out  1   regfile write enable, 1-cycle pulse
//  rf_wa        out  4   write address
//  rf_wdata     out  16  write data
//  alu_op       out  4   ALU opcode
//  alu_a        out  16  ALU busA
//  alu_b        out  16  ALU busB
//  alu_result   in   16  ALU result
//  alu_branch   in   1   ALU branch-taken
//  pc           out  16  current PC
//  halted       out  1   high in HALT
// BEHAVIOUR
//  Reset: state=IDLE; pc=RESET_PC; all other outputs 0. Reset mid-operation aborts immediately; no partial write.
//  Encoding: op=ins[15:12], drives alu_op directly.
//   - R-type (0,1,2,4,5,6,7): rd=[11:8], rn=[7:4], rm=[3:0]; a=R[rn], b=R[rm].
//   - F (passB): b={8'h00,ins[7:0]}, writes rd.
//   - 8 B / 9 BL: off=sext(ins[11:0]).
//   - A CBZ / B CBNZ: b=R[ins[11:8]], off=sext(ins[7:0]).
//   - E: HALT. Ops 3, C, D: NOP (no write, pc+1).
//  FSM:
//   - IDLE: run=1 -> FETCH.
//   - FETCH: imem_req=1, imem_addr=pc held stable. On imem_ack -> latch ins, req=0 next cycle, -> DECODE.
//   - DECODE (1 cyc): rf_ra/rf_rb from ins; alu_a/alu_b/alu_op registered at cycle end -> EXEC.
//     HALT detected here -> HALT.
//   - EXEC (1 cyc): ALU combinational; capture alu_result and alu_branch at cycle end -> WB.
//   - WB (1 cyc):
//     - R-type/F: rf_we=1, rf_wa=rd, rf_wdata=result.
//     - BL: rf_we=1, rf_wa=LINK_REG, rf_wdata=pc+1.
//     - pc <= branch ? pc+off : pc+1. -> FETCH.
//   - HALT: halted=1, imem_req=0. Run is ignored; exit only via rst_n.
//  Latency: 3 cycles + fetch wait per instruction; zero-wait fetch gives 4 cycles.
//  PC arithmetic is modulo 2^16; wrap is silent.
//  alu_branch is used only for ops 8..B; it is ignored for all other ops.
//  Writes to LINK_REG by R-type are legal.
//  imem_ack outside FETCH is ignored.
// CONFIGURATION
//  SEQ_RETIRE_CNT_EN defined:
//   - adds output retire_cnt[15:0]; reset 0.
//   - +1 in every WB cycle, wraps at 0xFFFF.
//   - holds value in HALT.
//  SEQ_RETIRE_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1 ADD: R2=5, R3=7; run; ins 0x4123, ack immediate -> WB: rf_we, wa=1, wdata=12; pc 0->1; 4 cycles.
//  2 Fetch stall: ack delayed 3 cycles -> imem_req high 4 cycles, imem_addr stable, rf_we=0 throughout.
//  3 CBZ: pc=10, 0xA4FE.
//    - R4=0 -> pc=8.
//    - R4=3 -> pc=11.
//    - No rf write in either case.
//  4 BL: pc=0xFFFE, 0x9005 -> R15=0xFFFF, pc=0x0003 (wrap).
//  5 Load-imm: 0xF3A5 -> R3=0x00A5.
//  6 HALT/reset:
//    - 0xE000 -> halted=1, imem_req stays 0, run ignored.
//    - rst_n pulse mid-WB -> rf_we drops immediately, no write, pc=RESET_PC.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle FETCH-DECODE-EXEC-WB sequencer driving a 16-bit ALU, regfile and imem port.
// Optional retire counter output enabled by defining SEQ_RETIRE_CNT_EN.
module alu_seq_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  LINK_REG = 4'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  rf_ra,
  output logic [3:0]  rf_rb,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [15:0] rf_wdata,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_branch,
  output logic [15:0] pc,
`ifdef SEQ_RETIRE_CNT_EN
  output logic [15:0] retire_cnt,
`endif
  output logic        halted
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ins_q, ins_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [15:0] res_q, res_d;
  logic        br_q, br_d;

  logic [3:0]  op;
  logic        is_rtype, is_ldi, is_bl, is_cb, is_branch;
  logic [15:0] off;

  assign op        = ins_q[15:12];
  assign is_rtype  = (op <= 4'h7) && (op != 4'h3);
  assign is_ldi    = (op == 4'hF);
  assign is_bl     = (op == 4'h9);
  assign is_cb     = (op == 4'hA) || (op == 4'hB);
  assign is_branch = (op[3:2] == 2'b10);
  assign off       = is_cb ? {{8{ins_q[7]}}, ins_q[7:0]} : {{4{ins_q[11]}}, ins_q[11:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      ins_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ins_q    <= ins_d;
      alu_op_q <= alu_op_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      res_q    <= res_d;
      br_q     <= br_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    res_d    = res_q;
    br_d     = br_q;
    imem_req = 1'b0;
    rf_ra    = '0;
    rf_rb    = '0;
    rf_we    = 1'b0;
    rf_wa    = '0;
    rf_wdata = '0;
    unique case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ins_d   = imem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        rf_ra = ins_q[7:4];
        rf_rb = is_cb ? ins_q[11:8] : ins_q[3:0];
        if (op == 4'hE) begin
          state_d = S_HALT;
        end else begin
          alu_op_d = op;
          alu_a_d  = (is_rtype || is_ldi) ? rf_rdata_a : 16'h0000;
          alu_b_d  = is_ldi ? {8'h00, ins_q[7:0]} : rf_rdata_b;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        br_d    = alu_branch;
        state_d = S_WB;
      end
      S_WB: begin
        if (is_rtype || is_ldi) begin
          rf_we    = 1'b1;
          rf_wa    = ins_q[11:8];
          rf_wdata = res_q;
        end else if (is_bl) begin
          rf_we    = 1'b1;
          rf_wa    = LINK_REG;
          rf_wdata = pc_q + 16'd1;
        end
        // branch flag only means something for ops 8..B
        pc_d    = (is_branch && br_q) ? pc_q + off : pc_q + 16'd1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign halted    = (state_q == S_HALT);

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt_q <= '0;
    else if (state_q == S_WB)  cnt_q <= cnt_q + 16'd1;
  end
  assign retire_cnt = cnt_q;
`endif

endmodule
